// File: rtl/dc_sweep_pkg.sv
// Shared types and default sizes for the DC sweep sequencer.
package dc_sweep_pkg;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_SETTLE_W = 16;
    localparam int DEF_AVG_LOG2 = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        MEASURE,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/dc_sweep_avg.sv
// Sample accumulator for one sweep point: sums 2^AVG_LOG2 samples and
// presents the truncated mean. The accumulator is wide enough that the
// full sum can never overflow.
module dc_sweep_avg
    import dc_sweep_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic              last_sample,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;

    // Clear has priority so an abort coinciding with an ack drops that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (add) begin
            acc   <= acc + ACC_W'(sample);
            count <= count + CNT_W'(1);
        end
    end

    assign last_sample = (count == LAST_IDX);
    assign result      = acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/dc_sweep_sequencer.sv
// DC operating-point sweep sequencer: steps the source DAC from v_start to
// v_stop, waits for the circuit to settle, averages load-node ADC samples
// and hands out one (code, result) pair per point.
module dc_sweep_sequencer
    import dc_sweep_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_W-1:0]   v_start,
    input  logic [DATA_W-1:0]   v_stop,
    input  logic [DATA_W-1:0]   v_step,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [DATA_W-1:0]   dac_code,
    output logic                dac_wr,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_code,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t state, next_state;

    logic [DATA_W-1:0]   cur;
    logic [DATA_W-1:0]   stop_r;
    logic [DATA_W-1:0]   step_r;
    logic [SETTLE_W-1:0] settle_r;
    logic [SETTLE_W-1:0] cnt;
    logic                cfg_done;
    logic                last_sample;
    logic [DATA_W-1:0]   avg_result;

    logic              abort_hit;
    logic              cfg_bad;
    logic              accept;
    logic [DATA_W:0]   next_sum;

    assign abort_hit = abort && (state != IDLE);
    assign cfg_bad   = (v_step == '0) || (v_stop < v_start);
    assign accept    = (state == EMIT) && res_ready;
    // One extra bit so a step past the top of the code range is seen as overshoot.
    assign next_sum  = {1'b0, cur} + {1'b0, step_r};

    dc_sweep_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (abort_hit || accept),
        .add         ((state == MEASURE) && adc_ack && !abort),
        .sample      (adc_data),
        .last_sample (last_sample),
        .result      (avg_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort from any active state returns straight to IDLE.
    always_comb begin
        next_state = state;
        if (abort_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !abort && !cfg_bad) next_state = LOAD;
                LOAD:    next_state = SETTLE;
                SETTLE:  if (cnt == '0) next_state = MEASURE;
                MEASURE: if (adc_ack && last_sample) next_state = EMIT;
                EMIT:    if (res_ready) next_state = (cur == stop_r) ? DONE : LOAD;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs that follow directly from the current state.
    always_comb begin
        busy      = (state != IDLE);
        adc_req   = (state == MEASURE);
        res_valid = (state == EMIT);
        done      = (state == DONE) || cfg_done;
    end

    assign res_code = cur;
    assign res_data = avg_result;

    // Sweep configuration capture, point stepping, DAC writes and settle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            stop_r   <= '0;
            step_r   <= '0;
            settle_r <= '0;
            cnt      <= '0;
            dac_code <= '0;
            dac_wr   <= 1'b0;
            err      <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            dac_wr   <= 1'b0;
            cfg_done <= 1'b0;
            if (abort_hit) begin
                dac_code <= '0;
                dac_wr   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (cfg_bad) begin
                                err      <= 1'b1;
                                cfg_done <= 1'b1;
                            end else begin
                                err      <= 1'b0;
                                cur      <= v_start;
                                stop_r   <= v_stop;
                                step_r   <= v_step;
                                settle_r <= settle_cycles;
                            end
                        end
                    end
                    LOAD: begin
                        dac_code <= cur;
                        dac_wr   <= 1'b1;
                        cnt      <= settle_r;
                    end
                    SETTLE: begin
                        if (cnt != '0) cnt <= cnt - SETTLE_W'(1);
                    end
                    EMIT: begin
                        if (res_ready && (cur != stop_r)) begin
                            cur <= (next_sum > {1'b0, stop_r}) ? stop_r : next_sum[DATA_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Directed testbench for dc_sweep_sequencer with a simple ADC responder
// and an event monitor that counts strobes and logs accepted results.
module tb_dc_sweep_sequencer;

    localparam int DATA_W   = 12;
    localparam int SETTLE_W = 16;
    localparam int AVG_LOG2 = 2;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [DATA_W-1:0]   v_start;
    logic [DATA_W-1:0]   v_stop;
    logic [DATA_W-1:0]   v_step;
    logic [SETTLE_W-1:0] settle_cycles;
    logic [DATA_W-1:0]   dac_code;
    logic                dac_wr;
    logic                adc_req;
    logic                adc_ack;
    logic [DATA_W-1:0]   adc_data;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_code;
    logic [DATA_W-1:0]   res_data;
    logic                busy;
    logic                done;
    logic                err;

    int   adc_mode;
    int   delay_max;
    logic stray_en;
    logic [DATA_W-1:0] adc_seq [4];

    int check_cnt = 0;
    int err_cnt   = 0;

    int cyc          = 0;
    int dac_wr_cnt   = 0;
    int done_cnt     = 0;
    int req_rise_cnt = 0;
    int res_cnt      = 0;
    int last_wr_cyc  = 0;
    int last_lat     = 0;
    logic prev_req_m = 1'b0;
    logic [DATA_W-1:0] res_code_log [64];
    logic [DATA_W-1:0] res_data_log [64];

    dc_sweep_sequencer #(
        .DATA_W   (DATA_W),
        .SETTLE_W (SETTLE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .v_start       (v_start),
        .v_stop        (v_stop),
        .v_step        (v_step),
        .settle_cycles (settle_cycles),
        .dac_code      (dac_code),
        .dac_wr        (dac_wr),
        .adc_req       (adc_req),
        .adc_ack       (adc_ack),
        .adc_data      (adc_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_code      (res_code),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // Event monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_req_m <= adc_req;
        if (dac_wr) begin
            dac_wr_cnt  <= dac_wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (adc_req && !prev_req_m) begin
            req_rise_cnt <= req_rise_cnt + 1;
            last_lat     <= cyc - last_wr_cyc;
        end
        if (res_valid && res_ready) begin
            res_code_log[res_cnt % 64] <= res_code;
            res_data_log[res_cnt % 64] <= res_data;
            res_cnt <= res_cnt + 1;
        end
    end

    // ADC responder: acks a held request after a random delay; optionally
    // also raises stray acks with junk data while no request is pending.
    initial begin : adc_model
        int   idx;
        int   wait_cnt;
        logic prev_req;
        adc_ack    = 1'b0;
        adc_data   = '0;
        idx        = 0;
        wait_cnt   = 0;
        prev_req   = 1'b0;
        adc_seq[0] = 12'd10;
        adc_seq[1] = 12'd11;
        adc_seq[2] = 12'd12;
        adc_seq[3] = 12'd14;
        forever begin
            @(posedge clk);
            #1;
            adc_ack = 1'b0;
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (adc_req) begin
                    if (!prev_req) begin
                        idx      = 0;
                        wait_cnt = int'($urandom_range(delay_max, 0));
                    end
                    if (wait_cnt == 0) begin
                        adc_ack  = 1'b1;
                        adc_data = (adc_mode == 1) ? adc_seq[idx % 4] : 12'd100;
                        idx      = idx + 1;
                        wait_cnt = int'($urandom_range(delay_max, 0));
                    end else begin
                        wait_cnt = wait_cnt - 1;
                    end
                end else if (stray_en) begin
                    adc_ack  = 1'b1;
                    adc_data = 12'd4000;
                end
                prev_req = adc_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput(tag, 64'({dac_code, dac_wr, adc_req, res_valid, res_code, res_data, busy, done, err}), 64'd0);
    endtask

    // Pulse start for one cycle, then scramble the config inputs.
    task automatic applyStimulus(input int vs, input int ve, input int vstep, input int settle);
        v_start       = DATA_W'(vs);
        v_stop        = DATA_W'(ve);
        v_step        = DATA_W'(vstep);
        settle_cycles = SETTLE_W'(settle);
        start         = 1'b1;
        tick();
        start         = 1'b0;
        v_start       = 12'hABC;
        v_stop        = 12'h001;
        v_step        = 12'h000;
        settle_cycles = 16'h7FFF;
    endtask

    task automatic waitDone(input string tag, input int base);
        int n = 0;
        while (done_cnt == base && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(done_cnt != base), 64'd1);
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!adc_req && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(adc_req), 64'd1);
    endtask

    task automatic waitRes(input string tag);
        int n = 0;
        while (!res_valid && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(res_valid), 64'd1);
    endtask

    task automatic sweepAndCheck(input string tag, input int vs, input int ve, input int vstep,
                                 input int settle, input int n_exp, input int codes [4], input int data_exp);
        int rb = res_cnt;
        int db = done_cnt;
        int wb = dac_wr_cnt;
        applyStimulus(vs, ve, vstep, settle);
        waitDone({tag, "_finish"}, db);
        repeat (2) tick();
        checkOutput({tag, "_count"}, 64'(res_cnt - rb), 64'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            checkOutput($sformatf("%s_code%0d", tag, i), 64'(res_code_log[(rb + i) % 64]), 64'(codes[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(res_data_log[(rb + i) % 64]), 64'(data_exp));
        end
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt - db), 64'd1);
        checkOutput({tag, "_dac_writes"}, 64'(dac_wr_cnt - wb), 64'(n_exp));
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Main directed sequence.
    initial begin
        int rb;
        int db;
        int wb;
        int qb;
        int unstable;

        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        v_start       = '0;
        v_stop        = '0;
        v_step        = '0;
        settle_cycles = '0;
        res_ready     = 1'b1;
        adc_mode      = 0;
        delay_max     = 0;
        stray_en      = 1'b0;
        repeat (3) tick();
        checkReset("reset_values");
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic sweep with constant ADC value.
        sweepAndCheck("t1", 0, 12, 4, 3, 4, '{0, 4, 8, 12}, 100);
        checkOutput("t1_wr_to_req_latency", 64'(last_lat), 64'd4);
        checkOutput("t1_dac_hold", 64'(dac_code), 64'd12);

        // Clamped last point, single top-of-range point, and carry-out clamp.
        sweepAndCheck("t2", 0, 10, 4, 2, 4, '{0, 4, 8, 10}, 100);
        sweepAndCheck("t3", 4095, 4095, 1, 0, 1, '{4095, 0, 0, 0}, 100);
        checkOutput("t3_dac_hold", 64'(dac_code), 64'd4095);
        sweepAndCheck("t3b", 4000, 4095, 100, 0, 2, '{4000, 4095, 0, 0}, 100);

        // Configuration errors, then a valid start clears the flag.
        rb = res_cnt; db = done_cnt; wb = dac_wr_cnt;
        applyStimulus(0, 10, 0, 1);
        waitDone("t4_step0_done", db);
        checkOutput("t4_step0_err", 64'(err), 64'd1);
        checkOutput("t4_step0_busy", 64'(busy), 64'd0);
        db = done_cnt;
        applyStimulus(5, 3, 1, 1);
        waitDone("t4_order_done", db);
        tick();
        checkOutput("t4_order_err", 64'(err), 64'd1);
        checkOutput("t4_no_dac_wr", 64'(dac_wr_cnt - wb), 64'd0);
        checkOutput("t4_no_results", 64'(res_cnt - rb), 64'd0);
        checkOutput("t4_err_done_pulses", 64'(done_cnt - db), 64'd1);
        db = done_cnt;
        applyStimulus(2, 2, 1, 0);
        checkOutput("t4_err_cleared", 64'(err), 64'd0);
        waitDone("t4_valid_done", db);
        repeat (2) tick();

        // Start and abort together in IDLE: no sweep.
        wb = dac_wr_cnt;
        abort = 1'b1;
        applyStimulus(0, 4, 4, 0);
        abort = 1'b0;
        checkOutput("t4_abort_wins_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("t4_abort_wins_wr", 64'(dac_wr_cnt - wb), 64'd0);

        // Averaging with random ack delay and stray acks outside requests.
        adc_mode  = 1;
        delay_max = 7;
        stray_en  = 1'b1;
        qb = req_rise_cnt;
        sweepAndCheck("t5", 7, 7, 1, 0, 1, '{7, 0, 0, 0}, 11);
        checkOutput("t5_req_held", 64'(req_rise_cnt - qb), 64'd1);
        adc_mode  = 0;
        delay_max = 0;
        stray_en  = 1'b0;
        tick();

        // Result back-pressure: outputs hold, no new DAC write, start ignored.
        res_ready = 1'b0;
        rb = res_cnt; db = done_cnt;
        applyStimulus(0, 4, 4, 1);
        waitRes("t6_first_valid");
        wb = dac_wr_cnt;
        applyStimulus(1, 2, 1, 0);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!res_valid || res_code != 12'd0 || res_data != 12'd100) unstable++;
        end
        checkOutput("t6_stable", 64'(unstable), 64'd0);
        checkOutput("t6_no_wr_stalled", 64'(dac_wr_cnt - wb), 64'd0);
        res_ready = 1'b1;
        waitDone("t6_finish", db);
        repeat (2) tick();
        checkOutput("t6_count", 64'(res_cnt - rb), 64'd2);
        checkOutput("t6_code0", 64'(res_code_log[rb % 64]), 64'd0);
        checkOutput("t6_code1", 64'(res_code_log[(rb + 1) % 64]), 64'd4);
        checkOutput("t6_data1", 64'(res_data_log[(rb + 1) % 64]), 64'd100);

        // Abort during SETTLE.
        rb = res_cnt; db = done_cnt; wb = dac_wr_cnt;
        applyStimulus(8, 12, 4, 10);
        repeat (4) tick();
        checkOutput("t7_pre_code", 64'(dac_code), 64'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t7_busy", 64'(busy), 64'd0);
        checkOutput("t7_safe_code", 64'(dac_code), 64'd0);
        checkOutput("t7_safe_wr", 64'(dac_wr), 64'd1);
        repeat (3) tick();
        checkOutput("t7_wr_count", 64'(dac_wr_cnt - wb), 64'd2);
        checkOutput("t7_no_done", 64'(done_cnt - db), 64'd0);

        // Abort during MEASURE on the cycle of the third ack.
        rb = res_cnt; db = done_cnt; wb = dac_wr_cnt;
        applyStimulus(8, 12, 4, 0);
        waitReq("t8_req_seen");
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t8_busy", 64'(busy), 64'd0);
        checkOutput("t8_req_low", 64'(adc_req), 64'd0);
        checkOutput("t8_safe_code", 64'(dac_code), 64'd0);
        checkOutput("t8_safe_wr", 64'(dac_wr), 64'd1);
        repeat (3) tick();
        checkOutput("t8_wr_count", 64'(dac_wr_cnt - wb), 64'd2);
        checkOutput("t8_no_done", 64'(done_cnt - db), 64'd0);
        checkOutput("t8_no_result", 64'(res_cnt - rb), 64'd0);
        sweepAndCheck("t8_after", 3, 3, 1, 0, 1, '{3, 0, 0, 0}, 100);

        // Abort during EMIT.
        res_ready = 1'b0;
        rb = res_cnt; db = done_cnt; wb = dac_wr_cnt;
        applyStimulus(20, 20, 1, 0);
        waitRes("t9_valid");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t9_valid_low", 64'(res_valid), 64'd0);
        checkOutput("t9_busy", 64'(busy), 64'd0);
        checkOutput("t9_safe_code", 64'(dac_code), 64'd0);
        checkOutput("t9_safe_wr", 64'(dac_wr), 64'd1);
        res_ready = 1'b1;
        repeat (3) tick();
        checkOutput("t9_wr_count", 64'(dac_wr_cnt - wb), 64'd2);
        checkOutput("t9_no_done", 64'(done_cnt - db), 64'd0);
        checkOutput("t9_no_result", 64'(res_cnt - rb), 64'd0);

        // Asynchronous reset in the middle of a sweep.
        applyStimulus(0, 12, 4, 3);
        waitReq("t10_req_seen");
        rst_n = 1'b0;
        #1;
        checkReset("t10_mid_reset");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
